mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV64 pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Contains a byte-addressable data memory with a configurable multi-cycle access latency and a stall handshake. Also contains the branch-resolution logic.
- Registers its results into MEM/WB-facing outputs for the writeback stage.

Parameters:
- MEM_BYTES, 512, data memory size in bytes; power of two.
- MEM_LATENCY, 2, cycles one load/store occupies; must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- RegWrite, MemtoReg, Branch, Zero, MemWrite, MemRead, is_greater  in  1 each  control from EX/MEM
- immvalue_added_pc  in  64  branch target from EX/MEM
- ALU_result  in  64  memory address, or result passed through to writeback
- WriteData  in  64  store data
- function_code  in  4  {instr[30], funct3}; only funct3 = function_code[2:0] is used
- destination_reg  in  5  rd
- stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM while high
- PCSrc  out  1  branch taken
- branch_target  out  64  equals immvalue_added_pc
- flush  out  1  flush for IF/ID, ID/EX and EX/MEM; equals PCSrc
- RegWrite_out, MemtoReg_out  out  1  to writeback
- ReadData_out, ALU_result_out  out  64  to writeback
- destination_reg_out  out  5  to writeback
- misaligned_err  out  1  single-cycle error pulse

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- On reset, at the clock edge:
  - FSM goes to IDLE, access counter = 0.
  - All registered outputs = 0.
  - All memory bytes = 0.
- Reset during BUSY abandons the access. No memory write occurs.
- Memory op: memop = MemRead | MemWrite.
- Address: addr = ALU_result mod MEM_BYTES. Upper bits are ignored, so addresses wrap.
- Byte order: little-endian.
- Access size from funct3[1:0]: 0 = byte, 1 = half, 2 = word, 3 = double.
- Loads:
  - 000 lb, 001 lh, 010 lw, 011 ld: sign-extend to 64 bits.
  - 100 lbu, 101 lhu, 110 lwu: zero-extend.
  - 111: treated as ld.
- Stores: use funct3[1:0] only (sb/sh/sw/sd). Only the addressed bytes change.
- MemRead and MemWrite both high: the store is performed and ReadData_out = 0.
- FSM states: IDLE and BUSY.
  - IDLE, no memop, or MEM_LATENCY == 1: outputs register at the next edge (latency 1). stall = 0.
  - IDLE, aligned memop, MEM_LATENCY > 1: stall = 1 combinationally. At the next edge go to BUSY with cnt = 1.
  - BUSY: stall = (cnt != MEM_LATENCY-1). cnt increments each edge.
  - BUSY completion: on the edge where stall = 0, the store commits or load data is captured, outputs register, and the FSM returns to IDLE.
  - Total occupancy: MEM_LATENCY cycles.
- Stall rules:
  - EX/MEM inputs are held stable by upstream while stall = 1. They are sampled only at the completion edge.
  - On every edge where stall = 1, RegWrite_out is registered as 0 (bubble).
  - ReadData_out, ALU_result_out and destination_reg_out hold their values during stall.
- Branch resolution (combinational; a branch never stalls):
  - funct3 000 beq: taken when Zero.
  - 001 bne: taken when !Zero.
  - 100 blt: taken when !is_greater & !Zero.
  - 101 bge: taken when is_greater | Zero.
  - Other funct3: not taken.
  - PCSrc = Branch & cond & !stall.
- Pass-through on a completing edge:
  - ALU_result_out = ALU_result.
  - destination_reg_out = destination_reg.
  - MemtoReg_out = MemtoReg.
  - RegWrite_out = RegWrite.
  - ReadData_out = load data, or 0 when not a load.
- Store data: a store writes WriteData; the upper bytes are truncated to the access size.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - A memop whose addr is not naturally aligned for its size suppresses the access: no write, ReadData_out = 0, RegWrite_out = 0.
  - The access completes in 1 cycle with no stall.
  - misaligned_err = 1 for the cycle following the edge; otherwise 0.
- Not defined:
  - addr low bits are cleared to natural alignment and the access proceeds normally.
  - misaligned_err is tied 0.

Test Plan:
- Reset: assert reset for 2 cycles with MemWrite = 1 -> all outputs 0, memory unchanged (still 0), stall = 0 after release.
- sd then ld, MEM_LATENCY = 2: sd of 0x1122334455667788 at 0x10, then ld at 0x10 -> each op holds stall high for 1 cycle; ReadData_out = 0x1122334455667788, RegWrite_out pulses once.
- Extension: sb 0x80 at 0x21, then lb and lbu at 0x21 -> lb gives 0xFFFFFFFFFFFFFF80, lbu gives 0x80; neighbouring bytes 0x20 and 0x22 unchanged.
- Branch: Branch = 1, funct3 = 001, Zero = 0, immvalue_added_pc = 0x40 -> PCSrc = flush = 1, branch_target = 0x40, no stall. With Zero = 1 -> PCSrc = 0.
- Wrap and misalignment: ALU_result = 0x205, 1-byte store with MEM_BYTES = 512 -> writes byte 0x005. With MEM_ALIGN_CHECK_EN, lw at 0x06 -> misaligned_err pulses, ReadData_out = 0, no stall.
- Reset mid-access: MEM_LATENCY = 4, sd issued, reset asserted in the 2nd BUSY cycle -> memory unchanged, FSM in IDLE, stall = 0 the next cycle.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Bundles the EX/MEM-facing inputs and the stall/branch/MEM-WB-facing outputs of
// the MEM stage so they can travel as one port.
//   master : upstream side. Drives the EX/MEM control/data. Observes stall,
//            branch and writeback results.
//   slave  : the MEM stage itself (mem_access_stage).
// Signals:
//   EX/MEM in : RegWrite, MemtoReg, Branch, Zero, MemWrite, MemRead, is_greater,
//               immvalue_added_pc[63:0], ALU_result[63:0], WriteData[63:0],
//               function_code[3:0] ({instr[30], funct3}), destination_reg[4:0]
//   outputs   : stall, PCSrc, branch_target[63:0], flush, RegWrite_out,
//               MemtoReg_out, ReadData_out[63:0], ALU_result_out[63:0],
//               destination_reg_out[4:0], misaligned_err
// -----------------------------------------------------------------------------
interface mem_access_stage_if;
   logic        RegWrite;
   logic        MemtoReg;
   logic        Branch;
   logic        Zero;
   logic        MemWrite;
   logic        MemRead;
   logic        is_greater;
   logic [63:0] immvalue_added_pc;
   logic [63:0] ALU_result;
   logic [63:0] WriteData;
   logic [3:0]  function_code;
   logic [4:0]  destination_reg;

   logic        stall;
   logic        PCSrc;
   logic [63:0] branch_target;
   logic        flush;
   logic        RegWrite_out;
   logic        MemtoReg_out;
   logic [63:0] ReadData_out;
   logic [63:0] ALU_result_out;
   logic [4:0]  destination_reg_out;
   logic        misaligned_err;

   modport master (
      output RegWrite, MemtoReg, Branch, Zero, MemWrite, MemRead, is_greater,
             immvalue_added_pc, ALU_result, WriteData, function_code, destination_reg,
      input  stall, PCSrc, branch_target, flush, RegWrite_out, MemtoReg_out,
             ReadData_out, ALU_result_out, destination_reg_out, misaligned_err
   );

   modport slave (
      input  RegWrite, MemtoReg, Branch, Zero, MemWrite, MemRead, is_greater,
             immvalue_added_pc, ALU_result, WriteData, function_code, destination_reg,
      output stall, PCSrc, branch_target, flush, RegWrite_out, MemtoReg_out,
             ReadData_out, ALU_result_out, destination_reg_out, misaligned_err
   );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM stage of a 5-stage RV64 pipeline. It has a byte-addressable little-endian
// data memory with a MEM_LATENCY-cycle access and a stall handshake. It also
// resolves branches and registers the MEM/WB-facing results.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset (FSM idle, outputs and memory cleared)
//   bus   : mem_access_stage_if.slave (EX/MEM inputs, stall/branch/WB outputs)
// Parameters:
//   MEM_BYTES   : memory size in bytes. Must be a power of two and >= 16.
//   MEM_LATENCY : cycles one load/store occupies. Must be >= 1.
// Optional build macro:
//   MEM_ALIGN_CHECK_EN : when defined, a misaligned memop is suppressed and
//                        completes in one cycle with a misaligned_err pulse.
//                        When undefined, the address is forced to natural
//                        alignment.
// -----------------------------------------------------------------------------
module mem_access_stage #(
   parameter int MEM_BYTES   = 512,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   mem_access_stage_if.slave bus
);
   localparam int AW = $clog2(MEM_BYTES);
   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [MEM_BYTES*8-1:0] mem_flat_s;

   logic [2:0]    funct3_s;
   logic [AW-1:0] addr_s, eff_addr_s;
   logic [2:0]    align_mask_s;
   logic [3:0]    nbytes_s;
   logic          misalign_s, memop_s, access_s, stall_s, store_commit_s;
   logic          br_cond_s, pcsrc_s;
   logic [63:0]   raw_s, load_s;
   logic          unused_funct7_s;

   logic        regwrite_q, regwrite_d, memtoreg_q, memtoreg_d, err_q, err_d;
   logic [63:0] read_data_q, read_data_d, alu_q, alu_d;
   logic [4:0]  rd_q, rd_d;

   assign funct3_s        = bus.function_code[2:0];
   assign unused_funct7_s = bus.function_code[3];
   assign addr_s          = bus.ALU_result[AW-1:0];
   assign memop_s         = bus.MemRead | bus.MemWrite;

   // Access size decode: byte count and the low-address mask for natural alignment.
   always_comb begin
      case (funct3_s[1:0])
         2'd0:    begin nbytes_s = 4'd1; align_mask_s = 3'b000; end
         2'd1:    begin nbytes_s = 4'd2; align_mask_s = 3'b001; end
         2'd2:    begin nbytes_s = 4'd4; align_mask_s = 3'b011; end
         2'd3:    begin nbytes_s = 4'd8; align_mask_s = 3'b111; end
         default: begin nbytes_s = 4'd1; align_mask_s = 3'b000; end
      endcase
   end

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign_s = |(addr_s[2:0] & align_mask_s);
   assign eff_addr_s = addr_s;
`else
   assign misalign_s = 1'b0;
   assign eff_addr_s = addr_s & ~AW'(align_mask_s);
`endif

   // A suppressed (misaligned) memop never occupies the memory.
   assign access_s       = memop_s & ~misalign_s;
   assign store_commit_s = ~stall_s & bus.MemWrite & access_s;

   // FSM state register: state and occupancy counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state: enter BUSY on a stalling access, leave on the completing edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (stall_s) begin
               state_d = BUSY;
               cnt_d   = CW'(1);
            end else begin
               state_d = IDLE;
               cnt_d   = {CW{1'b0}};
            end
         end
         BUSY: begin
            if (stall_s) begin
               state_d = BUSY;
               cnt_d   = cnt_q + CW'(1);
            end else begin
               state_d = IDLE;
               cnt_d   = {CW{1'b0}};
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CW{1'b0}};
         end
      endcase
   end

   // FSM output: stall until the last cycle of the access.
   always_comb begin
      stall_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (access_s && (MEM_LATENCY > 1)) stall_s = 1'b1;
            else                                stall_s = 1'b0;
         end
         BUSY:    stall_s = (cnt_q != CNT_LAST);
         default: stall_s = 1'b0;
      endcase
   end

   // One byte per generate slot. The byte's offset from the access base selects the write-data lane.
   for (genvar j = 0; j < MEM_BYTES; j++) begin : g_byte
      logic [AW-1:0] off_s;
      logic [7:0]    byte_q;
      assign off_s = AW'(j) - eff_addr_s;
      assign mem_flat_s[8*j +: 8] = byte_q;

      // Storage byte: cleared on reset, written on a committing store that covers it.
      always_ff @(posedge clk) begin
         if (reset) begin
            byte_q <= 8'h00;
         end else if (store_commit_s && (off_s < AW'(nbytes_s))) begin
            byte_q <= bus.WriteData[{off_s[2:0], 3'b000} +: 8];
         end else begin
            byte_q <= byte_q;
         end
      end
   end

   // Little-endian gather of eight bytes starting at the access base.
   always_comb begin
      raw_s = 64'd0;
      for (int i = 0; i < 8; i++) begin
         raw_s[8*i +: 8] = mem_flat_s[{eff_addr_s + AW'(i), 3'b000} +: 8];
      end
   end

   // Load extension. funct3 111 behaves as ld.
   always_comb begin
      case (funct3_s)
         3'b000:  load_s = {{56{raw_s[7]}},  raw_s[7:0]};
         3'b001:  load_s = {{48{raw_s[15]}}, raw_s[15:0]};
         3'b010:  load_s = {{32{raw_s[31]}}, raw_s[31:0]};
         3'b100:  load_s = {56'd0, raw_s[7:0]};
         3'b101:  load_s = {48'd0, raw_s[15:0]};
         3'b110:  load_s = {32'd0, raw_s[31:0]};
         default: load_s = raw_s;
      endcase
   end

   // Branch condition from funct3. is_greater/Zero come from the EX compare.
   always_comb begin
      case (funct3_s)
         3'b000:  br_cond_s = bus.Zero;
         3'b001:  br_cond_s = ~bus.Zero;
         3'b100:  br_cond_s = ~bus.is_greater & ~bus.Zero;
         3'b101:  br_cond_s = bus.is_greater | bus.Zero;
         default: br_cond_s = 1'b0;
      endcase
   end

   assign pcsrc_s = bus.Branch & br_cond_s & ~stall_s;

   // Writeback register next values: bubble while stalled, capture on completion.
   always_comb begin
      if (stall_s) begin
         regwrite_d  = 1'b0;
         memtoreg_d  = memtoreg_q;
         read_data_d = read_data_q;
         alu_d       = alu_q;
         rd_d        = rd_q;
         err_d       = 1'b0;
      end else begin
         regwrite_d  = bus.RegWrite & ~(memop_s & misalign_s);
         memtoreg_d  = bus.MemtoReg;
         read_data_d = (bus.MemRead && !bus.MemWrite && access_s) ? load_s : 64'd0;
         alu_d       = bus.ALU_result;
         rd_d        = bus.destination_reg;
         err_d       = memop_s & misalign_s;
      end
   end

   // Writeback registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         regwrite_q  <= 1'b0;
         memtoreg_q  <= 1'b0;
         read_data_q <= 64'd0;
         alu_q       <= 64'd0;
         rd_q        <= 5'd0;
         err_q       <= 1'b0;
      end else begin
         regwrite_q  <= regwrite_d;
         memtoreg_q  <= memtoreg_d;
         read_data_q <= read_data_d;
         alu_q       <= alu_d;
         rd_q        <= rd_d;
         err_q       <= err_d;
      end
   end

   assign bus.stall               = stall_s;
   assign bus.PCSrc               = pcsrc_s;
   assign bus.flush               = pcsrc_s;
   assign bus.branch_target       = bus.immvalue_added_pc;
   assign bus.RegWrite_out        = regwrite_q;
   assign bus.MemtoReg_out        = memtoreg_q;
   assign bus.ReadData_out        = read_data_q;
   assign bus.ALU_result_out      = alu_q;
   assign bus.destination_reg_out = rd_q;
   assign bus.misaligned_err      = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Directed scoreboard bench for mem_access_stage. u_dut uses MEM_LATENCY = 2.
// u_dut4 uses MEM_LATENCY = 4 for the reset-during-access case.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;
   logic clk;
   logic reset;
   logic reset4;
   int   total = 0;
   int   bad   = 0;

   typedef struct {
      logic [63:0] rd;
      logic        rw;
      logic        mtr;
      logic [63:0] alu;
      logic [4:0]  rdi;
      logic        err;
      int          stalls;
   } exp_t;

   exp_t sb_q[$];

   mem_access_stage_if bus ();
   mem_access_stage_if bus4 ();

   mem_access_stage #(.MEM_BYTES(512), .MEM_LATENCY(2)) u_dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );
   mem_access_stage #(.MEM_BYTES(512), .MEM_LATENCY(4)) u_dut4 (
      .clk(clk), .reset(reset4), .bus(bus4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit on4, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic regw,
                        input logic [4:0] rdi);
      if (on4) begin
         bus4.MemRead = rd_en; bus4.MemWrite = wr_en; bus4.MemtoReg = rd_en;
         bus4.RegWrite = regw; bus4.function_code = {1'b0, f3}; bus4.ALU_result = addr;
         bus4.WriteData = wdata; bus4.destination_reg = rdi; bus4.Branch = 1'b0;
         bus4.Zero = 1'b0; bus4.is_greater = 1'b0; bus4.immvalue_added_pc = 64'd0;
      end else begin
         bus.MemRead = rd_en; bus.MemWrite = wr_en; bus.MemtoReg = rd_en;
         bus.RegWrite = regw; bus.function_code = {1'b0, f3}; bus.ALU_result = addr;
         bus.WriteData = wdata; bus.destination_reg = rdi; bus.Branch = 1'b0;
         bus.Zero = 1'b0; bus.is_greater = 1'b0; bus.immvalue_added_pc = 64'd0;
      end
   endtask

   // Drive one op, push its expectation, follow the stall, then pop and compare at completion.
   task automatic issue(input string tag, input bit on4, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic regw, input logic [4:0] rdi, input logic [63:0] exp_rd,
                        input logic exp_rw, input logic exp_err, input int exp_stalls);
      exp_t e;
      int   stalls;
      bit   done;
      logic st;
      @(negedge clk);
      drive(on4, rd_en, wr_en, f3, addr, wdata, regw, rdi);
      e.rd = exp_rd; e.rw = exp_rw; e.mtr = rd_en; e.alu = addr; e.rdi = rdi;
      e.err = exp_err; e.stalls = exp_stalls;
      sb_q.push_back(e);
      stalls = 0;
      done   = 1'b0;
      for (int k = 0; k < 16 && !done; k++) begin
         #1;
         st = on4 ? bus4.stall : bus.stall;
         if (!st) begin
            done = 1'b1;
         end else begin
            stalls++;
            @(posedge clk);
            #1;
            chk({tag, "_bubble"}, 64'(on4 ? bus4.RegWrite_out : bus.RegWrite_out), 64'd0);
            @(negedge clk);
         end
      end
      if (!done) chk({tag, "_stall_timeout"}, 64'(on4 ? bus4.stall : bus.stall), 64'd0);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      if (on4) begin
         chk({tag, "_rdata"}, bus4.ReadData_out, e.rd);
         chk({tag, "_regwrite"}, 64'(bus4.RegWrite_out), 64'(e.rw));
      end else begin
         chk({tag, "_rdata"}, bus.ReadData_out, e.rd);
         chk({tag, "_regwrite"}, 64'(bus.RegWrite_out), 64'(e.rw));
         chk({tag, "_memtoreg"}, 64'(bus.MemtoReg_out), 64'(e.mtr));
         chk({tag, "_alu"}, bus.ALU_result_out, e.alu);
         chk({tag, "_rd"}, 64'(bus.destination_reg_out), 64'(e.rdi));
         chk({tag, "_err"}, 64'(bus.misaligned_err), 64'(e.err));
      end
      chk({tag, "_stalls"}, 64'(stalls), 64'(e.stalls));
   endtask

   // Drive a pure branch and check the combinational resolution.
   task automatic branch(input string tag, input logic [2:0] f3, input logic zero,
                         input logic gt, input logic [63:0] tgt, input logic exp_pc);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, f3, 64'd0, 64'd0, 1'b0, 5'd0);
      bus.Branch = 1'b1; bus.Zero = zero; bus.is_greater = gt; bus.immvalue_added_pc = tgt;
      #1;
      chk({tag, "_pcsrc"}, 64'(bus.PCSrc), 64'(exp_pc));
      chk({tag, "_flush"}, 64'(bus.flush), 64'(exp_pc));
      chk({tag, "_target"}, bus.branch_target, tgt);
      chk({tag, "_stall"}, 64'(bus.stall), 64'd0);
   endtask

   initial begin
      // Reset with a store pending: nothing may be written.
      reset  = 1'b1;
      reset4 = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 3'b011, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd3);
      drive(1'b1, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 5'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset  = 1'b0;
      reset4 = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 5'd0);
      #1;
      chk("rst_stall", 64'(bus.stall), 64'd0);
      chk("rst_rdata", bus.ReadData_out, 64'd0);
      chk("rst_alu", bus.ALU_result_out, 64'd0);
      chk("rst_regwrite", 64'(bus.RegWrite_out), 64'd0);
      chk("rst_memtoreg", 64'(bus.MemtoReg_out), 64'd0);
      chk("rst_rd", 64'(bus.destination_reg_out), 64'd0);
      chk("rst_err", 64'(bus.misaligned_err), 64'd0);
      issue("rst_mem", 1'b0, 1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 1'b1, 5'd3, 64'd0, 1'b1, 1'b0, 1);

      // sd then ld, plus funct3 111 as ld.
      issue("sd", 1'b0, 1'b0, 1'b1, 3'b011, 64'h10, 64'h1122334455667788, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1);
      issue("ld", 1'b0, 1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 1'b1, 5'd5, 64'h1122334455667788, 1'b1, 1'b0, 1);
      issue("ld111", 1'b0, 1'b1, 1'b0, 3'b111, 64'h10, 64'd0, 1'b1, 5'd6, 64'h1122334455667788, 1'b1, 1'b0, 1);

      // Byte store with truncation, sign/zero extension, neighbours untouched.
      issue("sb", 1'b0, 1'b0, 1'b1, 3'b000, 64'h21, 64'hDEADBEEFCAFEBA80, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1);
      issue("lb", 1'b0, 1'b1, 1'b0, 3'b000, 64'h21, 64'd0, 1'b1, 5'd8, 64'hFFFFFFFFFFFFFF80, 1'b1, 1'b0, 1);
      issue("lbu", 1'b0, 1'b1, 1'b0, 3'b100, 64'h21, 64'd0, 1'b1, 5'd9, 64'h80, 1'b1, 1'b0, 1);
      issue("lbu20", 1'b0, 1'b1, 1'b0, 3'b100, 64'h20, 64'd0, 1'b1, 5'd9, 64'h0, 1'b1, 1'b0, 1);
      issue("lbu22", 1'b0, 1'b1, 1'b0, 3'b100, 64'h22, 64'd0, 1'b1, 5'd9, 64'h0, 1'b1, 1'b0, 1);

      // Half and word sizes.
      issue("sh", 1'b0, 1'b0, 1'b1, 3'b001, 64'h30, 64'h123456789ABC8001, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1);
      issue("lh", 1'b0, 1'b1, 1'b0, 3'b001, 64'h30, 64'd0, 1'b1, 5'd10, 64'hFFFFFFFFFFFF8001, 1'b1, 1'b0, 1);
      issue("lhu", 1'b0, 1'b1, 1'b0, 3'b101, 64'h30, 64'd0, 1'b1, 5'd10, 64'h8001, 1'b1, 1'b0, 1);
      issue("lbu32", 1'b0, 1'b1, 1'b0, 3'b100, 64'h32, 64'd0, 1'b1, 5'd10, 64'h0, 1'b1, 1'b0, 1);
      issue("sw", 1'b0, 1'b0, 1'b1, 3'b010, 64'h40, 64'hFFFFFFFF80000001, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1);
      issue("lw", 1'b0, 1'b1, 1'b0, 3'b010, 64'h40, 64'd0, 1'b1, 5'd11, 64'hFFFFFFFF80000001, 1'b1, 1'b0, 1);
      issue("lwu", 1'b0, 1'b1, 1'b0, 3'b110, 64'h40, 64'd0, 1'b1, 5'd11, 64'h80000001, 1'b1, 1'b0, 1);
      issue("lbu44", 1'b0, 1'b1, 1'b0, 3'b100, 64'h44, 64'd0, 1'b1, 5'd11, 64'h0, 1'b1, 1'b0, 1);

      // MemRead and MemWrite together: store happens, ReadData_out is 0.
      issue("rdwr", 1'b0, 1'b1, 1'b1, 3'b011, 64'h50, 64'hA5A55A5A0F0FF0F0, 1'b0, 5'd12, 64'd0, 1'b0, 1'b0, 1);
      issue("rdwr_chk", 1'b0, 1'b1, 1'b0, 3'b011, 64'h50, 64'd0, 1'b1, 5'd12, 64'hA5A55A5A0F0FF0F0, 1'b1, 1'b0, 1);

      // ALU pass-through, no memop: single cycle.
      issue("alu", 1'b0, 1'b0, 1'b0, 3'b000, 64'h123456789ABCDEF0, 64'd0, 1'b1, 5'd7, 64'd0, 1'b1, 1'b0, 0);

      // Address wrap: 0x205 aliases byte 0x005.
      issue("wrap_sb", 1'b0, 1'b0, 1'b1, 3'b000, 64'h205, 64'hA5, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1);
      issue("wrap_lbu", 1'b0, 1'b1, 1'b0, 3'b100, 64'h005, 64'd0, 1'b1, 5'd13, 64'hA5, 1'b1, 1'b0, 1);

      // lw at 0x06: suppressed with an error pulse, or forced down to 0x04.
`ifdef MEM_ALIGN_CHECK_EN
      issue("mis_lw", 1'b0, 1'b1, 1'b0, 3'b010, 64'h06, 64'd0, 1'b1, 5'd14, 64'd0, 1'b0, 1'b1, 0);
`else
      issue("mis_lw", 1'b0, 1'b1, 1'b0, 3'b010, 64'h06, 64'd0, 1'b1, 5'd14, 64'hA500, 1'b1, 1'b0, 1);
`endif
      issue("after_mis", 1'b0, 1'b0, 1'b0, 3'b000, 64'h77, 64'd0, 1'b0, 5'd15, 64'd0, 1'b0, 1'b0, 0);

      // Branch resolution.
      branch("bne_taken", 3'b001, 1'b0, 1'b0, 64'h40, 1'b1);
      branch("bne_not", 3'b001, 1'b1, 1'b0, 64'h40, 1'b0);
      branch("blt_taken", 3'b100, 1'b0, 1'b0, 64'h88, 1'b1);
      branch("bge_not", 3'b101, 1'b0, 1'b0, 64'h88, 1'b0);
      branch("bge_taken", 3'b101, 1'b0, 1'b1, 64'h90, 1'b1);
      branch("f3_other", 3'b010, 1'b1, 1'b1, 64'h90, 1'b0);

      // A stall masks PCSrc. Dropping the memop before the edge unmasks it.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 3'b000, 64'h21, 64'd0, 1'b0, 5'd0);
      bus.Branch = 1'b1; bus.Zero = 1'b1; bus.immvalue_added_pc = 64'hC0;
      #1;
      chk("br_stall_stall", 64'(bus.stall), 64'd1);
      chk("br_stall_pcsrc", 64'(bus.PCSrc), 64'd0);
      bus.MemRead = 1'b0;
      #1;
      chk("br_nostall_pcsrc", 64'(bus.PCSrc), 64'd1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 5'd0);

      // MEM_LATENCY = 4: reset during the 2nd BUSY cycle abandons the sd.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 3'b011, 64'h10, 64'hCAFEF00DDEADBEEF, 1'b0, 5'd0);
      #1;
      chk("l4_stall0", 64'(bus4.stall), 64'd1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("l4_stall2", 64'(bus4.stall), 64'd1);
      reset4 = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 5'd0);
      @(negedge clk);
      reset4 = 1'b0;
      #1;
      chk("l4_rst_stall", 64'(bus4.stall), 64'd0);
      issue("l4_ld", 1'b1, 1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 1'b1, 5'd2, 64'd0, 1'b1, 1'b0, 3);
      issue("l4_sd", 1'b1, 1'b0, 1'b1, 3'b011, 64'h18, 64'h0102030405060708, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 3);
      issue("l4_ld2", 1'b1, 1'b1, 1'b0, 3'b011, 64'h18, 64'd0, 1'b1, 5'd2, 64'h0102030405060708, 1'b1, 1'b0, 3);

      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 5'd0);
      drive(1'b1, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 5'd0);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
